// File: rtl/crc32_stream.sv
// Streaming CRC-32 (zlib/PNG) engine: accepts one word at a time, folds up to
// BPC bytes per cycle, MSB byte first, and pulses val_o/done_o per word/message.
module crc32_stream #(
  parameter int          DATA_WD = 32,
  parameter int          BPC     = 1,
  parameter logic [31:0] INIT    = 32'hFFFF_FFFF,
  parameter logic [31:0] XOR_OUT = 32'hFFFF_FFFF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic                          val_i,
  output logic                          rdy_o,
  input  logic [DATA_WD-1:0]            dat_i,
  input  logic                          lst_i,
  input  logic [$clog2(DATA_WD/8):0]    nbyte_i,
  output logic                          val_o,
  output logic                          done_o,
  output logic [31:0]                   dat_o
);

  localparam int          NB    = DATA_WD / 8;
  localparam int          CW    = $clog2(NB) + 1;
  localparam logic [CW-1:0] NB_C  = CW'(NB);
  localparam logic [CW-1:0] BPC_C = CW'(BPC);
  localparam logic [31:0] POLY  = 32'hEDB8_8320;

  typedef enum logic [1:0] {IDLE, ACTV, PROC} state_t;

  state_t             state_r, state_nx;
  logic [31:0]        crc_r, crc_nx;
  logic [DATA_WD-1:0] word_r, word_nx;
  logic               lst_r;
  logic [CW-1:0]      rem_r, take, nb_clamp;
  logic               fin;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  assign rdy_o = (state_r == ACTV);
  assign dat_o = crc_r ^ XOR_OUT;

  // The byte currently due is always kept at the top of word_r, so each PROC
  // cycle folds from the top and shifts the consumed bytes out.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    take     = (rem_r < BPC_C) ? rem_r : BPC_C;
    fin      = (state_r == PROC) && (rem_r <= BPC_C);
    nb_clamp = (nbyte_i == '0 || nbyte_i > NB_C) ? NB_C : nbyte_i;
    crc_nx   = crc_r;
    word_nx  = word_r;
    for (int i = 0; i < BPC; i++) begin
      if (i < int'(take)) begin
        crc_nx  = crc_byte(crc_nx, word_nx[DATA_WD-1 -: 8]);
        word_nx = word_nx << 8;
      end
    end
  end

  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE:    if (start_i) state_nx = ACTV;
      ACTV:    if (val_i)   state_nx = PROC;
      PROC:    if (fin)     state_nx = lst_r ? IDLE : ACTV;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_r  <= '0;
      rem_r  <= '0;
      val_o  <= 1'b0;
      done_o <= 1'b0;
    end else begin
      val_o  <= fin;
      done_o <= fin & lst_r;
      case (state_r)
        IDLE: if (start_i) crc_r <= INIT;
        ACTV: if (val_i)   rem_r <= lst_i ? nb_clamp : NB_C;
        PROC: begin
          crc_r <= crc_nx;
          rem_r <= rem_r - take;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the captured word is pure datapath; it is always written before use,
  // so it carries no reset.
  always_ff @(posedge clk) begin
    if (state_r == ACTV && val_i) begin
      word_r <= dat_i;
      lst_r  <= lst_i;
    end else if (state_r == PROC) begin
      word_r <= word_nx;
    end
  end

endmodule

// File: tb/tb_crc32_stream.sv
// Self-checking bench for crc32_stream: three configurations driven from one
// directed/randomized sequence, checked against a table-driven CRC-32 model.
module tb_crc32_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          sel = 0;
  logic        start_v = 1'b0, val_v = 1'b0, lst_v = 1'b0;
  logic [63:0] dat_v = '0;
  logic [3:0]  nb_v = '0;

  logic        rdy0, valo0, done0, rdy1, valo1, done1, rdy2, valo2, done2;
  logic [31:0] dato0, dato1, dato2;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  msg[$];
  logic [31:0] tbl[256];
  logic [31:0] last_crc;
  bit          nb_fuzz = 1'b0;

  always #5 clk = ~clk;

  crc32_stream #(.DATA_WD(32), .BPC(1)) u_w32_b1 (
    .clk(clk), .rst(rst), .start_i(start_v && sel == 0), .val_i(val_v && sel == 0),
    .rdy_o(rdy0), .dat_i(dat_v[31:0]), .lst_i(lst_v), .nbyte_i(nb_v[2:0]),
    .val_o(valo0), .done_o(done0), .dat_o(dato0));

  crc32_stream #(.DATA_WD(32), .BPC(2)) u_w32_b2 (
    .clk(clk), .rst(rst), .start_i(start_v && sel == 1), .val_i(val_v && sel == 1),
    .rdy_o(rdy1), .dat_i(dat_v[31:0]), .lst_i(lst_v), .nbyte_i(nb_v[2:0]),
    .val_o(valo1), .done_o(done1), .dat_o(dato1));

  crc32_stream #(.DATA_WD(64), .BPC(8)) u_w64_b8 (
    .clk(clk), .rst(rst), .start_i(start_v && sel == 2), .val_i(val_v && sel == 2),
    .rdy_o(rdy2), .dat_i(dat_v), .lst_i(lst_v), .nbyte_i(nb_v),
    .val_o(valo2), .done_o(done2), .dat_o(dato2));

  function automatic logic cur_rdy();
    return (sel == 0) ? rdy0 : (sel == 1) ? rdy1 : rdy2;
  endfunction
  function automatic logic cur_valo();
    return (sel == 0) ? valo0 : (sel == 1) ? valo1 : valo2;
  endfunction
  function automatic logic cur_done();
    return (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
  endfunction
  function automatic logic [31:0] cur_dato();
    return (sel == 0) ? dato0 : (sel == 1) ? dato1 : dato2;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference CRC-32 over the first n bytes of msg, byte-at-a-time via a table.
  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) c = tbl[c[7:0] ^ msg[i]] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic load_str(input string s);
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
  endtask

  task automatic wait_rdy(input string tag, output bit ok);
    int guard;
    guard = 0;
    while (!cur_rdy() && guard < 60) begin step(); guard++; end
    ok = cur_rdy();
    if (!ok) check({tag, "_rdy_timeout"}, 64'd0, 64'd1);
  endtask

  // Stream msg through DUT s. held: the next word is presented with val_i=1
  // while the current one is still being folded. poke: stray start_i pulses.
  task automatic run_msg(input int s, input bit held, input bit poke, input string tag);
    int          wb, bpc, nw, len, off, m, g;
    logic [63:0] words[$];
    int          ns[$];
    logic [3:0]  nbs[$];
    bit          ok;
    sel = s;
    wb  = (s == 2) ? 8 : 4;
    bpc = (s == 0) ? 1 : (s == 1) ? 2 : 8;
    len = msg.size();
    off = 0;
    while (off < len) begin
      logic [63:0] w;
      int n;
      n = (len - off < wb) ? len - off : wb;
      w = {$urandom, $urandom};
      for (int k = 0; k < n; k++) w[wb*8-1-8*k -: 8] = msg[off+k];
      words.push_back(w);
      ns.push_back(n);
      if (off + n == len && n == wb && nb_fuzz && $urandom_range(0, 1) == 1)
        nbs.push_back($urandom_range(0, 1) == 1 ? 4'd0 : 4'(wb + 1 + $urandom_range(0, wb - 2)));
      else
        nbs.push_back(4'(n));
      off += n;
    end
    nw = words.size();

    start_v = 1'b1; step(); start_v = 1'b0;
    off = 0;
    dat_v = words[0]; lst_v = (nw == 1); nb_v = nbs[0]; val_v = 1'b1;
    for (int i = 0; i < nw; i++) begin
      wait_rdy(tag, ok);
      if (!ok) begin val_v = 1'b0; return; end
      step();
      check({tag, "_proc_rdy"}, 64'(cur_rdy()), 64'd0);
      check({tag, "_proc_valo"}, 64'(cur_valo()), 64'd0);
      if (held && i + 1 < nw) begin
        dat_v = words[i+1]; lst_v = (i + 2 == nw); nb_v = nbs[i+1]; val_v = 1'b1;
      end else begin
        val_v = 1'b0;
      end
      if (poke) start_v = 1'b1;
      m = 1;
      while (!cur_valo() && m < 40) begin step(); start_v = 1'b0; m++; end
      start_v = 1'b0;
      off += ns[i];
      check({tag, "_latency"}, 64'(m), 64'((ns[i] + bpc - 1) / bpc + 1));
      check({tag, "_done"}, 64'(cur_done()), 64'(i + 1 == nw));
      check({tag, "_crc"}, 64'(cur_dato()), 64'(ref_crc(off)));
      if (i + 1 == nw) begin
        last_crc = cur_dato();
        step();
        check({tag, "_valo_pulse"}, 64'({cur_valo(), cur_done()}), 64'd0);
        check({tag, "_idle_rdy"}, 64'(cur_rdy()), 64'd0);
        step(); step();
        check({tag, "_hold"}, 64'(cur_dato()), 64'(last_crc));
      end else if (!held) begin
        g = $urandom_range(0, 2);
        repeat (g) begin
          start_v = poke; step(); start_v = 1'b0;
        end
        dat_v = words[i+1]; lst_v = (i + 2 == nw); nb_v = nbs[i+1]; val_v = 1'b1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, seen;
    int m;
    for (int b = 0; b < 256; b++) begin
      logic [31:0] v;
      v = 32'(b);
      for (int j = 0; j < 8; j++) v = v[0] ? ((v >> 1) ^ 32'hEDB8_8320) : (v >> 1);
      tbl[b] = v;
    end

    // Reset state of all three configurations, with val_i/start_i idle.
    rst = 1'b1;
    step(); step();
    check("rst_rdy", 64'({rdy0, rdy1, rdy2}), 64'd0);
    check("rst_valo", 64'({valo0, valo1, valo2}), 64'd0);
    check("rst_done", 64'({done0, done1, done2}), 64'd0);
    check("rst_dato0", 64'(dato0), 64'hFFFF_FFFF);
    check("rst_dato1", 64'(dato1), 64'hFFFF_FFFF);
    check("rst_dato2", 64'(dato2), 64'hFFFF_FFFF);
    rst = 1'b0;
    step();

    // val_i in IDLE must not be taken.
    sel = 0; val_v = 1'b1; dat_v = 64'h1234_5678; step(); step();
    check("idle_val_ignored", 64'({rdy0, valo0}), 64'd0);
    val_v = 1'b0;

    load_str("IEND");
    run_msg(0, 1'b0, 1'b0, "iend_b1");
    check("iend_b1_kat", 64'(last_crc), 64'hAE42_6082);

    load_str("123456789");
    run_msg(1, 1'b0, 1'b0, "check_b2");
    check("check_b2_kat", 64'(last_crc), 64'hCBF4_3926);

    load_str("a");
    run_msg(2, 1'b0, 1'b0, "a_b8");
    check("a_b8_kat", 64'(last_crc), 64'hE8B7_BE43);

    load_str("123456789");
    run_msg(0, 1'b1, 1'b0, "backpressure");
    check("backpressure_kat", 64'(last_crc), 64'hCBF4_3926);

    load_str("IEND");
    run_msg(1, 1'b0, 1'b1, "start_poke");
    check("start_poke_kat", 64'(last_crc), 64'hAE42_6082);

    // Reset during PROC of the second word discards the message.
    sel = 0;
    start_v = 1'b1; step(); start_v = 1'b0;
    dat_v = 64'h4142_4344; lst_v = 1'b0; nb_v = 4'd4; val_v = 1'b1;
    wait_rdy("abort_w1", ok);
    step(); val_v = 1'b0;
    m = 0;
    while (!valo0 && m < 20) begin step(); m++; end
    check("abort_w1_valo", 64'(valo0), 64'd1);
    dat_v = 64'h4546_4748; lst_v = 1'b1; val_v = 1'b1;
    wait_rdy("abort_w2", ok);
    step(); val_v = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    check("abort_rdy", 64'(rdy0), 64'd0);
    check("abort_dato", 64'(dato0), 64'hFFFF_FFFF);
    check("abort_pulses", 64'({valo0, done0}), 64'd0);
    seen = 1'b0;
    repeat (8) begin step(); if (valo0 || done0) seen = 1'b1; end
    check("abort_no_done", 64'(seen), 64'd0);
    load_str("IEND");
    run_msg(0, 1'b0, 1'b0, "after_abort");
    check("after_abort_kat", 64'(last_crc), 64'hAE42_6082);

    // Randomized messages across configurations and flow-control styles.
    nb_fuzz = 1'b1;
    for (int t = 0; t < 24; t++) begin
      int len;
      len = $urandom_range(1, 24);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      run_msg($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/crc32_stream.md
CRC32_STREAM -- requirements
Module: crc32_stream

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, input word width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter BPC, default 1, bytes folded into the CRC per cycle; legal values 1, 2, 4, 8; BPC <= DATA_WD/8.
REQ-003 SHALL have parameter INIT, default 32'hFFFF_FFFF, CRC register preset.
REQ-004 SHALL have parameter XOR_OUT, default 32'hFFFF_FFFF, final xor.
REQ-005 SHALL use one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-006 Ports SHALL be, in order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  begin a new CRC
- val_i  in  1  input word valid
- rdy_o  out  1  block accepts a word this cycle
- dat_i  in  DATA_WD  input word
- lst_i  in  1  word is the last of the message
- nbyte_i  in  $clog2(DATA_WD/8)+1  valid byte count of the last word
- val_o  out  1  word-processed pulse
- done_o  out  1  message-complete pulse
- dat_o  out  32  CRC result

Function
REQ-007 CRC SHALL be CRC-32 (PNG/zlib): reflected polynomial 0xEDB88320, bits within each byte LSB-first.
REQ-008 Byte order SHALL be MSB-first: byte k is dat_i[DATA_WD-1-8k -: 8], k = 0 first.
REQ-009 FSM SHALL have three states: IDLE, ACTV, PROC.
REQ-010 IDLE: start_i=1 -> crc_r <= INIT, go to ACTV; otherwise hold. start_i is ignored outside IDLE.
REQ-011 rdy_o SHALL equal 1 only in ACTV.
REQ-012 ACTV: val_i=1 -> capture dat_i and lst_i; remaining count <= nbyte_i if lst_i=1, else DATA_WD/8; go to PROC. val_i=0 -> hold.
REQ-013 On the last word, nbyte_i = 0 or nbyte_i > DATA_WD/8 SHALL be treated as DATA_WD/8; the unused low-order bytes are ignored.
REQ-014 PROC: each cycle SHALL fold min(BPC, remaining) bytes, in byte order, into crc_r and decrement remaining by that amount.
REQ-015 When remaining reaches 0, the FSM SHALL go to IDLE if the captured lst_i=1, otherwise to ACTV.
REQ-016 A word of n valid bytes SHALL occupy ceil(n/BPC) PROC cycles; throughput is one word per 1+ceil(n/BPC) cycles.
REQ-017 val_o SHALL be a registered 1-cycle pulse in the cycle after the final PROC cycle of every word.
REQ-018 done_o SHALL pulse in the same cycle as val_o, for the last word only.
REQ-019 dat_o SHALL continuously equal crc_r ^ XOR_OUT; it is valid for the message while val_o=1 and holds until the next start_i.
REQ-020 val_i while rdy_o=0 SHALL be ignored, with no state change; the source holds the word until rdy_o=1.

Reset
REQ-021 rst=1 at a clock edge SHALL force state IDLE, crc_r=0, remaining=0, val_o=0, done_o=0, and hence rdy_o=0 and dat_o=XOR_OUT.
REQ-022 rst asserted mid-message SHALL discard the partial CRC; no val_o or done_o pulse is issued for that message.

Verification
REQ-023 DATA_WD=32, BPC=1: start; word 32'h49454E44 ("IEND") with lst_i=1, nbyte_i=4 accepted at cycle T -> PROC in T+1..T+4; val_o=done_o=1 at T+5; dat_o=32'hAE426082.
REQ-024 DATA_WD=32, BPC=2: words 32'h31323334, 32'h35363738, then 32'h39xxxxxx with lst_i=1, nbyte_i=1 -> val_o three times, done_o on the third; dat_o=32'hCBF43926.
REQ-025 DATA_WD=64, BPC=8: word 32'h61 placed in the top byte, lst_i=1, nbyte_i=1 -> one PROC cycle; dat_o=32'hE8B7BE43.
REQ-026 Backpressure: hold val_i=1 through PROC -> rdy_o=0 and no second capture; the word is accepted on return to ACTV and the CRC is unchanged vs a gapped stream.
REQ-027 Assert rst during PROC of word 2 -> next cycle state IDLE, rdy_o=0, dat_o=32'hFFFFFFFF, no done_o; a following "IEND" run gives 32'hAE426082.
REQ-028 start_i pulsed in ACTV/PROC -> ignored, CRC result unchanged.
